// File: rtl/pz_term_loader.sv
// Serial pole/zero term loader: assembles a frame into a shadow bank, commits it to the
// active bank and opens a PIPE_DEPTH-cycle pz_ready window. Optional counters: PZ_TERM_LOADER_FRAME_CNT_EN.
module pz_term_loader #(
  parameter int REG_FILE_SIZE = 8,
  parameter int DATA_SIZE     = 8,
  parameter int PIPE_DEPTH    = 3
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_SIZE-1:0]               in_data,
  input  logic                               in_is_pole,
  input  logic                               in_last,
  output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
  output logic [31:0]                        no_z,
  output logic [31:0]                        no_p,
  output logic                               pz_ready,
  output logic                               frame_err
`ifdef PZ_TERM_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0]                        frame_cnt,
  output logic [15:0]                        err_cnt
`endif
);

  // state       | meaning
  // LOAD_Z      | accepting zero terms (a pole moves to LOAD_P)
  // LOAD_P      | accepting pole terms only
  // DRAIN       | frame is bad, discard beats until in_last
  // WAIT_COMMIT | frame complete, commit once the current window is ending
  typedef enum logic [1:0] {LOAD_Z, LOAD_P, DRAIN, WAIT_COMMIT} state_t;

  localparam int IW   = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
  localparam int CW   = $clog2(REG_FILE_SIZE + 1);
  localparam int UW   = CW + 1;
  localparam int WINW = $clog2(PIPE_DEPTH + 1);

  state_t                            state;
  logic [CW-1:0]                     wp, nz, np, nz_act, np_act;
  logic [DATA_SIZE-1:0]              shadow [REG_FILE_SIZE];
  logic [WINW-1:0]                   win_cnt;
  logic [DATA_SIZE*REG_FILE_SIZE-1:0] staged;
  logic [UW-1:0]                     used;
  logic                              xfer, overflow, bad, commit;

  assign in_ready = (state != WAIT_COMMIT);
  assign pz_ready = (win_cnt != '0);
  assign no_z     = {{(32-CW){1'b0}}, nz_act};
  assign no_p     = {{(32-CW){1'b0}}, np_act};

  assign xfer     = in_valid && in_ready;
  assign overflow = (wp == CW'(REG_FILE_SIZE));
  assign bad      = overflow || ((state == LOAD_P) && !in_is_pole);
  // Committing while the counter is at 1 reloads it seamlessly for back-to-back frames.
  assign commit   = (state == WAIT_COMMIT) && (win_cnt <= WINW'(1));
  assign used     = UW'(nz) + UW'(np);

  always_comb begin
    staged = '0;
    for (int i = 0; i < REG_FILE_SIZE; i++)
      if (UW'(i) < used) staged[DATA_SIZE*i +: DATA_SIZE] = shadow[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= LOAD_Z;
      wp        <= '0;
      nz        <= '0;
      np        <= '0;
      nz_act    <= '0;
      np_act    <= '0;
      win_cnt   <= '0;
      flat_pz   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < REG_FILE_SIZE; i++) shadow[i] <= '0;
`ifdef PZ_TERM_LOADER_FRAME_CNT_EN
      frame_cnt <= '0;
      err_cnt   <= '0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
      case (state)
        LOAD_Z, LOAD_P: begin
          if (xfer) begin
            if (bad) begin
              if (in_last) begin
                frame_err <= 1'b1;
                wp        <= '0;
                nz        <= '0;
                np        <= '0;
                state     <= LOAD_Z;
`ifdef PZ_TERM_LOADER_FRAME_CNT_EN
                err_cnt   <= err_cnt + 1'b1;
`endif
              end else begin
                state <= DRAIN;
              end
            end else begin
              shadow[wp[IW-1:0]] <= in_data;
              wp <= wp + 1'b1;
              if (in_is_pole) np <= np + 1'b1;
              else            nz <= nz + 1'b1;
              if (in_last)         state <= WAIT_COMMIT;
              else if (in_is_pole) state <= LOAD_P;
            end
          end
        end
        DRAIN: begin
          if (xfer && in_last) begin
            frame_err <= 1'b1;
            wp        <= '0;
            nz        <= '0;
            np        <= '0;
            state     <= LOAD_Z;
`ifdef PZ_TERM_LOADER_FRAME_CNT_EN
            err_cnt   <= err_cnt + 1'b1;
`endif
          end
        end
        WAIT_COMMIT: begin
          if (commit) begin
            flat_pz <= staged;
            nz_act  <= nz;
            np_act  <= np;
            win_cnt <= WINW'(PIPE_DEPTH);
            wp      <= '0;
            nz      <= '0;
            np      <= '0;
            state   <= LOAD_Z;
`ifdef PZ_TERM_LOADER_FRAME_CNT_EN
            frame_cnt <= frame_cnt + 1'b1;
`endif
          end
        end
        default: state <= LOAD_Z;
      endcase
    end
  end

endmodule

// File: doc/pz_term_loader.md
Name: pz_term_loader

Overview:
- Upstream feeder for the pole/zero accumulator stage.
- Accepts a serial valid/ready stream of log-magnitude terms, each tagged as zero or pole, and assembles one frame into a shadow register file.
- On frame end, commits the frame to an active bank that drives flat_pz/no_z/no_p, then asserts pz_ready for exactly PIPE_DEPTH cycles so the accumulator pipeline flushes the new frame.
- Ordering contract: zeros occupy indices 0..nz-1, poles occupy nz..nz+np-1.

Parameters:
- REG_FILE_SIZE, 8, number of term slots; must be a power of two, at most 15.
- DATA_SIZE, 8, width of one term in bits.
- PIPE_DEPTH, 3, number of cycles pz_ready is held per committed frame; matches the accumulator latency.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  input term valid.
- in_ready  output  1  loader can accept a term.
- in_data  input  DATA_SIZE  term value.
- in_is_pole  input  1  0 = zero term, 1 = pole term.
- in_last  input  1  last term of the frame.
- flat_pz  output  DATA_SIZE*REG_FILE_SIZE  active bank; slot i at bits [DATA_SIZE*i +: DATA_SIZE].
- no_z  output  32  committed zero count, zero-extended.
- no_p  output  32  committed pole count, zero-extended.
- pz_ready  output  1  accumulator enable window.
- frame_err  output  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async assert, sync release): flat_pz=0, no_z=0, no_p=0, pz_ready=0, frame_err=0, in_ready=1, state=LOAD_Z, write pointer wp=0, shadow counts 0, window counter 0.
- A beat transfers when in_valid && in_ready. in_data, in_is_pole and in_last are sampled only on a transfer.
- LOAD_Z:
  - Zero beat: shadow[wp]<=data; wp++; nz++.
  - Pole beat: shadow[wp]<=data; wp++; np++; go to LOAD_P.
- LOAD_P:
  - Pole beat: store; wp++; np++.
  - Zero beat: ordering error; go to DRAIN.
- Overflow: a beat arriving with wp==REG_FILE_SIZE is not stored and goes to DRAIN.
- DRAIN:
  - in_ready=1; beats are discarded.
  - On the in_last transfer: pulse frame_err the next cycle, clear wp/nz/np, go to LOAD_Z.
  - If the error beat itself has in_last, the frame_err pulse and return to LOAD_Z happen immediately.
- Normal frame end (in_last on a valid beat in LOAD_Z/LOAD_P):
  - If the window counter is 0: commit on the next edge.
  - Otherwise go to WAIT_COMMIT with in_ready=0, and commit on the cycle the window counter reaches 0.
- Commit:
  - Active bank <= shadow, with unused slots forced to 0.
  - no_z<=nz, no_p<=np.
  - Window counter <= PIPE_DEPTH; clear wp/nz/np; go to LOAD_Z.
- pz_ready = (window counter != 0).
  - Goes high the cycle after commit and stays high exactly PIPE_DEPTH cycles.
  - flat_pz/no_z/no_p remain stable throughout the window and until the next commit.
- A frame may be loaded into shadow while a window is active (double buffering). Only the commit is deferred.
- Back-to-back commits: pz_ready stays continuously high; each frame gets a full PIPE_DEPTH cycles.
- Counts are at most REG_FILE_SIZE, so they fit the accumulator's 4-bit count fields.
- Reset mid-frame or mid-window: all state is discarded immediately and there is no commit.

Optional Feature:
- Macro: PZ_TERM_LOADER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0], incremented on each commit.
  - Adds output err_cnt [15:0], incremented on each frame_err.
  - Both counters wrap at 0xFFFF->0 and reset to 0.
- When undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then send zeros 0x10, 0x20 and pole 0x05 (last) -> one cycle later: flat_pz[7:0]=0x10, [15:8]=0x20, [23:16]=0x05, upper slots 0; no_z=2, no_p=1; pz_ready high exactly 3 cycles.
- Send zero 0x01, pole 0x02, then zero 0x03 (last) -> frame_err pulses once; flat_pz/no_z/no_p unchanged; pz_ready stays 0.
- Send 10 zero terms (last on the 10th) with REG_FILE_SIZE=8 -> frame_err pulses; the next frame commits normally with no_z counting only its own terms.
- Send a 1-term frame, then a second 1-term frame (last) during the first window -> in_ready drops; second commit lands as the window ends; pz_ready stays high 6 cycles total.
- Assert resetn=0 asynchronously, between clock edges, in the middle of a window -> pz_ready=0, no_z=0, flat_pz=0 immediately.
- With PZ_TERM_LOADER_FRAME_CNT_EN defined: 3 good frames and 1 bad frame -> frame_cnt=3, err_cnt=1.
